atm_controller: RTL and testbench
=================================

// Module: atm_controller
// PURPOSE
//   Session controller for a single-account ATM front end. Sequences card insertion, PIN
//   acknowledgement and a transaction menu: withdraw, deposit, balance inquiry, language select.
//   Keeps the account balance internally and drives cash/deposit strobes and display outputs.
//   Sits between the panel/keypad input logic and the dispenser/display drivers.
// PARAMETERS
//   INIT_BALANCE  16'd1000  account balance loaded at reset
//   WITHDRAW_AMT  16'd100   amount debited per successful withdrawal
//   DEPOSIT_AMT   16'd100   amount credited per deposit
//   PIN_TIMEOUT   32        cycles allowed in WAIT_PIN before lockout (>=1)
// PORTS
//   clk              in   1   single clock, all logic on rising edge
//   reset            in   1   synchronous, active-high
//   card_in          in   1   level: card present
//   pin_entry        in   1   level: valid PIN acknowledged by keypad logic
//   withdrawal       in   1   request; acted on rising edge only
//   deposit          in   1   request; acted on rising edge only
//   balance_inquiry  in   1   request; acted on rising edge only
//   language_select  in   1   request; acted on rising edge only
//   ready            out  1   high while in MENU (session authenticated, idle)
//   error            out  1   1-cycle pulse on rejected transaction; steady high in LOCKED
//   cash             out  1   1-cycle pulse: dispense WITHDRAW_AMT
//   deposit_complete out  1   1-cycle pulse: deposit credited
//   balance          out  16  displayed balance (latched on inquiry)
//   language         out  2   session language code 0..3
// BEHAVIOUR
//   - All outputs registered. Reset: state=IDLE, ready=0, error=0, cash=0, deposit_complete=0,
//     balance=0, language=0, account=INIT_BALANCE, edge-detect history regs=0.
//   - Request edges: req_rise = req & ~req_q; req_q updated every cycle in every state.
//   - States: IDLE, WAIT_PIN, MENU, LOCKED.
//     IDLE: card_in=1 -> WAIT_PIN, pin timer cleared, language=0.
//     WAIT_PIN: pin_entry=1 -> MENU (ready=1 from next cycle); timer reaches PIN_TIMEOUT
//       without pin_entry -> LOCKED.
//     MENU: service at most one request per cycle, priority
//       withdrawal > deposit > balance_inquiry > language_select; lower-priority edges
//       arriving the same cycle are dropped (need a new rising edge).
//     LOCKED: error=1 steady, ready=0; exits to IDLE only when card_in=0.
//   - card_in=0 in any non-IDLE state -> IDLE next cycle: ready=0, balance display=0,
//     language=0, pending actions discarded. Account value is retained across sessions.
//   - Withdraw (1-cycle latency): account>=WITHDRAW_AMT -> account-=WITHDRAW_AMT, cash pulse;
//     else account unchanged, error pulse. Exact equality succeeds (balance becomes 0).
//   - Deposit: account+DEPOSIT_AMT <= 16'hFFFF -> credit, deposit_complete pulse;
//     else (would overflow) account unchanged, error pulse. No wrap-around ever.
//   - Balance inquiry: balance output <= current account value; held until next inquiry
//     or session end (not auto-updated by later transactions).
//   - Language: language <= language+1, wrapping 3->0.
//   - Requests outside MENU are ignored (no pulses, no error) apart from edge-history update.
//   - Requests held high across entry to MENU are not serviced; a new rising edge is needed.
//   - Pulses never exceed one cycle; cash, deposit_complete and the transaction error pulse
//     are mutually exclusive.
//   - Reset mid-session aborts to IDLE and restores INIT_BALANCE.
// TESTING
//   1 reset; card_in=1; pin_entry=1 -> ready=1 two cycles after card sampled; error=0.
//   2 MENU, withdrawal held 10 cycles -> single cash pulse; inquiry then shows balance=900.
//   3 MENU, deposit edge -> deposit_complete pulse; inquiry -> balance=1000 (from 900).
//   4 ten withdrawals from 1000 -> balance 0; eleventh -> error pulse, no cash, stays 0.
//   5 card_in=1, pin_entry=0 for PIN_TIMEOUT cycles -> LOCKED, error high; card_in=0 -> IDLE.
//   6 language_select x5 edges -> language 1,2,3,0,1; card_in=0 -> language=0, balance=0.

Source files
------------

// File: rtl/atm_if.sv
// atm_if: panel/keypad requests in, dispenser/display strobes out
interface atm_if;
  logic        card_in;
  logic        pin_entry;
  logic        withdrawal;
  logic        deposit;
  logic        balance_inquiry;
  logic        language_select;
  logic        ready;
  logic        error;
  logic        cash;
  logic        deposit_complete;
  logic [15:0] balance;
  logic [1:0]  language;
  modport master (
    output card_in, pin_entry, withdrawal, deposit, balance_inquiry, language_select,
    input  ready, error, cash, deposit_complete, balance, language
  );
  modport slave (
    input  card_in, pin_entry, withdrawal, deposit, balance_inquiry, language_select,
    output ready, error, cash, deposit_complete, balance, language
  );
endinterface

// File: rtl/atm_controller.sv
// atm_controller: ATM session sequencer with internal account and registered strobes
module atm_controller #(
  parameter logic [15:0] INIT_BALANCE = 16'd1000,
  parameter logic [15:0] WITHDRAW_AMT = 16'd100,
  parameter logic [15:0] DEPOSIT_AMT  = 16'd100,
  parameter int          PIN_TIMEOUT  = 32
) (
  input logic clk,
  input logic reset,
  atm_if.slave bus
);
  localparam int TW = $clog2(PIN_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT_PIN, MENU, LOCKED} state_t;
  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [15:0]     account_q, account_d, balance_q, balance_d;
  logic [1:0]      language_q, language_d;
  logic            ready_q, error_q, cash_q, cash_d, dep_q, dep_d, txn_err;
  logic [3:0]      req, req_q, rise;
  logic [16:0]     dep_sum;
  assign req     = {bus.withdrawal, bus.deposit, bus.balance_inquiry, bus.language_select};
  assign rise    = req & ~req_q;
  assign dep_sum = {1'b0, account_q} + {1'b0, DEPOSIT_AMT};
  assign bus.ready            = ready_q;
  assign bus.error            = error_q;
  assign bus.cash             = cash_q;
  assign bus.deposit_complete = dep_q;
  assign bus.balance          = balance_q;
  assign bus.language         = language_q;
  // next state and transaction outcome; losing the card overrides everything
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    account_d  = account_q;
    balance_d  = balance_q;
    language_d = language_q;
    cash_d     = 1'b0;
    dep_d      = 1'b0;
    txn_err    = 1'b0;
    if (state_q != IDLE && !bus.card_in) begin
      state_d    = IDLE;
      balance_d  = '0;
      language_d = '0;
    end else begin
      case (state_q)
        IDLE: if (bus.card_in) begin
          state_d    = WAIT_PIN;
          timer_d    = '0;
          language_d = '0;
        end
        WAIT_PIN: if (bus.pin_entry) state_d = MENU;
          else if (timer_q == TW'(PIN_TIMEOUT - 1)) state_d = LOCKED;
          else timer_d = timer_q + TW'(1);
        MENU: if (rise[3]) begin
          cash_d    = account_q >= WITHDRAW_AMT;
          txn_err   = !cash_d;
          account_d = cash_d ? account_q - WITHDRAW_AMT : account_q;
        end else if (rise[2]) begin
          dep_d     = !dep_sum[16];
          txn_err   = dep_sum[16];
          account_d = dep_d ? dep_sum[15:0] : account_q;
        end else if (rise[1]) balance_d = account_q;
          else if (rise[0]) language_d = language_q + 2'd1;
        default: ;
      endcase
    end
  end
  // state, account and registered outputs; request history tracks every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      account_q  <= INIT_BALANCE;
      balance_q  <= '0;
      language_q <= '0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      cash_q     <= 1'b0;
      dep_q      <= 1'b0;
      req_q      <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      account_q  <= account_d;
      balance_q  <= balance_d;
      language_q <= language_d;
      ready_q    <= state_d == MENU;
      error_q    <= txn_err || state_d == LOCKED;
      cash_q     <= cash_d;
      dep_q      <= dep_d;
      req_q      <= req;
    end
  end
endmodule

// File: tb/tb_atm_controller.sv
// tb_atm_controller: directed scenarios plus randomized run against a session model
module tb_atm_controller;
  localparam int T = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  atm_if bus();
  atm_controller #(.INIT_BALANCE(16'd1000), .WITHDRAW_AMT(16'd100), .DEPOSIT_AMT(16'd100),
                   .PIN_TIMEOUT(T)) dut (.clk(clk), .reset(reset), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  int m_phase, m_wait, m_acct, m_bal, m_lang;
  bit m_ready, m_err, m_cash, m_dep;
  bit [3:0] m_prev;
  // session model: 0 no card, 1 awaiting pin, 2 menu, 3 locked
  task automatic model_step();
    bit [3:0] r, e;
    bit terr;
    r = {bus.withdrawal, bus.deposit, bus.balance_inquiry, bus.language_select};
    e = r & ~m_prev;
    terr = 0; m_cash = 0; m_dep = 0;
    if (reset) begin
      m_phase = 0; m_wait = 0; m_acct = 1000; m_bal = 0; m_lang = 0; m_prev = 0;
    end else begin
      if (m_phase != 0 && !bus.card_in) begin
        m_phase = 0; m_bal = 0; m_lang = 0;
      end else if (m_phase == 0 && bus.card_in) begin
        m_phase = 1; m_wait = 0; m_lang = 0;
      end else if (m_phase == 1) begin
        if (bus.pin_entry) m_phase = 2;
        else begin
          m_wait++;
          if (m_wait == T) m_phase = 3;
        end
      end else if (m_phase == 2) begin
        if (e[3]) begin
          if (m_acct >= 100) begin m_acct -= 100; m_cash = 1; end else terr = 1;
        end else if (e[2]) begin
          if (m_acct + 100 <= 65535) begin m_acct += 100; m_dep = 1; end else terr = 1;
        end else if (e[1]) m_bal = m_acct;
        else if (e[0]) m_lang = (m_lang + 1) % 4;
      end
      m_prev = r;
    end
    m_ready = m_phase == 2;
    m_err = terr || m_phase == 3;
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    {bus.card_in, bus.pin_entry, bus.withdrawal, bus.deposit, bus.balance_inquiry, bus.language_select} = '0;
    tick(); tick();
    reset = 1'b0;
  endtask
  task automatic login();
    bus.card_in = 1'b1; bus.pin_entry = 1'b1;
    tick(); tick();
  endtask
  task automatic inquire();
    bus.balance_inquiry = 1'b1; tick();
    bus.balance_inquiry = 1'b0; tick();
  endtask
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({bus.ready, bus.error, bus.cash, bus.deposit_complete, bus.balance, bus.language} !== 22'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got r%b e%b c%b d%b bal%0d lang%0d required all zero",
               bus.ready, bus.error, bus.cash, bus.deposit_complete, bus.balance, bus.language);
    end
  endtask
  task automatic test_login();
    bus.card_in = 1'b1; bus.pin_entry = 1'b1;
    tick();
    n_cmp++;
    if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL login_early_ready: got %b required 0", bus.ready); end
    tick();
    n_cmp++;
    if ({bus.ready, bus.error} !== 2'b10) begin
      n_bad++; $display("FAIL login_ready: got ready=%b error=%b required ready=1 error=0", bus.ready, bus.error);
    end
  endtask
  task automatic test_withdraw_held();
    int cnt = 0;
    bus.withdrawal = 1'b1;
    repeat (10) begin tick(); cnt += int'(bus.cash); end
    bus.withdrawal = 1'b0; tick();
    n_cmp++;
    if (cnt != 1) begin n_bad++; $display("FAIL held_withdraw_pulses: got %0d required 1", cnt); end
    inquire();
    n_cmp++;
    if (bus.balance !== 16'd900) begin n_bad++; $display("FAIL balance_900: got %0d required 900", bus.balance); end
  endtask
  task automatic test_deposit();
    bus.deposit = 1'b1; tick();
    n_cmp++;
    if (bus.deposit_complete !== 1'b1) begin n_bad++; $display("FAIL deposit_pulse: got %b required 1", bus.deposit_complete); end
    bus.deposit = 1'b0; tick();
    inquire();
    n_cmp++;
    if (bus.balance !== 16'd1000) begin n_bad++; $display("FAIL balance_1000: got %0d required 1000", bus.balance); end
  endtask
  task automatic test_drain();
    int cnt = 0;
    for (int i = 0; i < 10; i++) begin
      bus.withdrawal = 1'b1; tick(); cnt += int'(bus.cash);
      bus.withdrawal = 1'b0; tick();
    end
    n_cmp++;
    if (cnt != 10) begin n_bad++; $display("FAIL drain_cash_count: got %0d required 10", cnt); end
    bus.withdrawal = 1'b1; tick();
    n_cmp++;
    if ({bus.cash, bus.error} !== 2'b01) begin
      n_bad++; $display("FAIL overdraw: got cash=%b error=%b required cash=0 error=1", bus.cash, bus.error);
    end
    bus.withdrawal = 1'b0; tick();
    n_cmp++;
    if (bus.error !== 1'b0) begin n_bad++; $display("FAIL overdraw_pulse_width: got error=%b required 0", bus.error); end
    inquire();
    n_cmp++;
    if (bus.balance !== 16'd0) begin n_bad++; $display("FAIL balance_zero: got %0d required 0", bus.balance); end
  endtask
  task automatic test_overflow();
    int cnt = 0;
    for (int i = 0; i < 655; i++) begin
      bus.deposit = 1'b1; tick(); cnt += int'(bus.deposit_complete);
      bus.deposit = 1'b0; tick();
    end
    n_cmp++;
    if (cnt != 655) begin n_bad++; $display("FAIL deposit_count: got %0d required 655", cnt); end
    bus.deposit = 1'b1; tick();
    n_cmp++;
    if ({bus.deposit_complete, bus.error} !== 2'b01) begin
      n_bad++; $display("FAIL deposit_overflow: got done=%b error=%b required done=0 error=1", bus.deposit_complete, bus.error);
    end
    bus.deposit = 1'b0; tick();
    inquire();
    n_cmp++;
    if (bus.balance !== 16'd65500) begin n_bad++; $display("FAIL balance_max: got %0d required 65500", bus.balance); end
  endtask
  task automatic test_reset_mid();
    reset = 1'b1; tick(); reset = 1'b0;
    bus.card_in = 1'b0; tick();
    login();
    inquire();
    n_cmp++;
    if (bus.balance !== 16'd1000) begin n_bad++; $display("FAIL reset_restores: got %0d required 1000", bus.balance); end
  endtask
  task automatic test_held_entry();
    int cnt = 0;
    do_reset();
    bus.withdrawal = 1'b1;
    tick();
    bus.card_in = 1'b1; bus.pin_entry = 1'b1;
    repeat (5) begin tick(); cnt += int'(bus.cash) + int'(bus.error); end
    bus.withdrawal = 1'b0;
    n_cmp++;
    if (cnt != 0) begin n_bad++; $display("FAIL held_across_entry: got %0d pulses required 0", cnt); end
  endtask
  task automatic test_lockout();
    do_reset();
    bus.card_in = 1'b1; bus.pin_entry = 1'b0;
    tick();
    repeat (T - 1) tick();
    n_cmp++;
    if (bus.error !== 1'b0) begin n_bad++; $display("FAIL lock_early: got error=%b required 0", bus.error); end
    tick();
    n_cmp++;
    if ({bus.error, bus.ready} !== 2'b10) begin
      n_bad++; $display("FAIL locked: got error=%b ready=%b required error=1 ready=0", bus.error, bus.ready);
    end
    bus.pin_entry = 1'b1; repeat (3) tick();
    n_cmp++;
    if ({bus.error, bus.ready} !== 2'b10) begin
      n_bad++; $display("FAIL lock_steady: got error=%b ready=%b required error=1 ready=0", bus.error, bus.ready);
    end
    bus.card_in = 1'b0; bus.pin_entry = 1'b0; tick();
    n_cmp++;
    if (bus.error !== 1'b0) begin n_bad++; $display("FAIL unlock_idle: got error=%b required 0", bus.error); end
  endtask
  task automatic test_language();
    do_reset();
    login();
    for (int i = 0; i < 5; i++) begin
      bus.language_select = 1'b1; tick();
      n_cmp++;
      if (int'(bus.language) != (i + 1) % 4) begin
        n_bad++; $display("FAIL language_step%0d: got %0d required %0d", i, bus.language, (i + 1) % 4);
      end
      bus.language_select = 1'b0; tick();
    end
    inquire();
    bus.card_in = 1'b0; tick();
    n_cmp++;
    if ({bus.language, bus.balance, bus.ready} !== 19'd0) begin
      n_bad++; $display("FAIL session_end: got lang=%0d bal=%0d ready=%b required 0 0 0", bus.language, bus.balance, bus.ready);
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(999) == 0;
      bus.card_in = $urandom_range(99) < 96;
      bus.pin_entry = $urandom_range(99) < 15;
      bus.withdrawal = $urandom_range(99) < 35;
      bus.deposit = $urandom_range(99) < 35;
      bus.balance_inquiry = $urandom_range(99) < 30;
      bus.language_select = $urandom_range(99) < 30;
      tick();
      n_cmp++;
      if ({bus.ready, bus.error, bus.cash, bus.deposit_complete, bus.balance, bus.language} !==
          {m_ready, m_err, m_cash, m_dep, 16'(m_bal), 2'(m_lang)}) begin
        n_bad++;
        $display("FAIL random_cycle%0d: got r%b e%b c%b d%b bal%0d lang%0d required r%b e%b c%b d%b bal%0d lang%0d",
                 i, bus.ready, bus.error, bus.cash, bus.deposit_complete, bus.balance, bus.language,
                 m_ready, m_err, m_cash, m_dep, m_bal, m_lang);
      end
    end
    reset = 1'b0;
  endtask
  initial begin
    test_reset();
    test_login();
    test_withdraw_held();
    test_deposit();
    test_drain();
    test_overflow();
    test_reset_mid();
    test_held_entry();
    test_lockout();
    test_language();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
